mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, meaning the RAM byte-address width (2^ADDR_WIDTH bytes).
REQ-002 SHALL have parameter TX_DEPTH_BIT, default 3, meaning log2 of the TX FIFO depth (8 entries).
REQ-003 SHALL have port clk_in  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cpu_a  input  32  byte address from the CPU.
REQ-006 SHALL have port cpu_wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cpu_dout  input  8  write data from the CPU.
REQ-008 SHALL have port cpu_din  output  8  read data returned to the CPU.
REQ-009 SHALL have port io_buffer_full  output  1  TX FIFO nearly full.
REQ-010 SHALL have port tx_data  output  8  FIFO head byte toward the UART.
REQ-011 SHALL have port tx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port tx_ready  input  1  UART accepts tx_data.
REQ-013 SHALL have port rx_data  input  8  byte from the UART.
REQ-014 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-015 SHALL have port rx_ready  output  1  the holding register is empty.
REQ-016 SHALL have port program_finished  output  1  sticky; set by a write to 0x30004.
REQ-017 SHALL have port tx_overflow  output  1  sticky; set when a push hits a full FIFO.

Function
REQ-018 SHALL decode IO when cpu_a[17:16]==2'b11; otherwise RAM at cpu_a[ADDR_WIDTH-1:0].
REQ-019 SHALL perform an RAM write of cpu_dout at the clock edge when cpu_wr=1 and the address is RAM.
REQ-020 SHALL register every read: cpu_din in cycle N+1 reflects the request presented in cycle N (1-cycle latency, every cycle, no handshake).
REQ-021 SHALL make cpu_din return the new byte on a RAM read in cycle N+1 of the address written in cycle N.
REQ-022 SHALL make cpu_din hold its previous value in the cycle after a write.
REQ-023 SHALL, on an IO read of 0x30000, return the held RX byte and clear the holding register.
REQ-024 SHALL, on an IO read of 0x30000 with an empty holding register, return 0x00.
REQ-025 SHALL keep a 32-bit cycle counter that increments every cycle after reset and wraps from 0xFFFFFFFF to 0.
REQ-026 SHALL, on an IO read of 0x30004, return counter[7:0] and snapshot the full counter.
REQ-027 SHALL, on IO reads of 0x30005/6/7, return snapshot bytes 1/2/3 (little-endian, coherent dword).
REQ-028 SHALL, on an IO write to 0x30000 of a nonzero byte, push it into the TX FIFO.
REQ-029 SHALL ignore an IO write of 0x00 to 0x30000.
REQ-030 SHALL, on an IO write to 0x30004, push 0x00 into the FIFO and set program_finished.
REQ-031 SHALL return 0x00 on reads of other IO addresses and ignore writes to them.
REQ-032 SHALL drive tx_valid = (count != 0) and tx_data = the head entry.
REQ-033 SHALL pop the FIFO when tx_valid && tx_ready.
REQ-034 SHALL, on a simultaneous push and pop, leave count unchanged and keep FIFO order.
REQ-035 SHALL, on a push to a full FIFO (count == 2^TX_DEPTH_BIT) without a simultaneous pop, drop the byte and set tx_overflow.
REQ-036 SHALL drive io_buffer_full = (count >= 2^TX_DEPTH_BIT - 1), combinational from count, giving one slot of slack for an in-flight write.
REQ-037 SHALL wrap the read and write pointers modulo the depth; count spans 0..depth.
REQ-038 SHALL drive rx_ready = !hold_valid and capture rx_data when rx_valid && rx_ready.
REQ-039 SHALL, on a same-cycle capture and read of an empty holding register, return 0x00 and make the new byte valid next cycle.

Reset
REQ-040 SHALL, while rst_in=0, asynchronously clear cpu_din=0x00, FIFO pointers and count=0, tx_valid=0, io_buffer_full=0, cycle counter and snapshot=0, hold_valid=0 (rx_ready=1), program_finished=0, and tx_overflow=0.
REQ-041 SHALL NOT clear RAM contents on reset.
REQ-042 SHALL, on reset assertion mid-operation, discard queued TX bytes and any pending read.
REQ-043 SHALL start counting at 1 in the first cycle after rst_in rises.

Verification
REQ-044 Write 0xA5 to 0x00010 in cycle N, read 0x00010 in cycle N+1 -> cpu_din=0xA5 in cycle N+2.
REQ-045 Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41 then 0x42 only; program_finished=0.
REQ-046 Hold tx_ready=0, write 7 nonzero bytes -> io_buffer_full=1 after the 7th; 8th write fills FIFO; 9th write sets tx_overflow=1 and 0x00..first 8 bytes drain unchanged.
REQ-047 Present rx_valid=1 with rx_data=0x33, then read 0x30000 twice -> cpu_din 0x33 then 0x00; rx_ready returns to 1.
REQ-048 Release reset, read 0x30004..0x30007 in consecutive cycles starting at cycle 100 -> bytes form 100 exactly; write 0x30004 -> program_finished=1 and tx_data=0x00.
REQ-049 Assert rst_in=0 with 3 bytes queued -> tx_valid=0, cpu_din=0x00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_io_responder.sv
// Memory and IO responder for a simple 8-bit CPU bus.
// RAM lives below the IO window. The IO window is selected by cpu_a[17:16] == 2'b11
// and provides:
//   - an RX holding register
//   - a free-running cycle counter with a coherent snapshot
//   - a TX FIFO toward the UART
//   - a program-finished flag
// Every read is registered, with exactly one cycle of latency.
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_BIT = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_finished,
    output logic        tx_overflow
);

    localparam int DEPTH    = 1 << TX_DEPTH_BIT;
    localparam int CNT_W    = TX_DEPTH_BIT + 1;
    localparam int RAM_SIZE = 1 << ADDR_WIDTH;

    // IO register offsets inside the IO window
    localparam logic [15:0] OFF_UART  = 16'h0000;
    localparam logic [15:0] OFF_CNT_0 = 16'h0004;
    localparam logic [15:0] OFF_CNT_1 = 16'h0005;
    localparam logic [15:0] OFF_CNT_2 = 16'h0006;
    localparam logic [15:0] OFF_CNT_3 = 16'h0007;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  is_io;
    logic [15:0]           io_off;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  unused_addr_bits;

    assign is_io            = (cpu_a[17:16] == 2'b11);
    assign io_off           = cpu_a[15:0];
    assign ram_addr         = cpu_a[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^cpu_a[31:18];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]              cpu_din_q, cpu_din_d;
    logic [31:0]             cycle_q, cycle_d;
    logic [31:0]             snap_q, snap_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [7:0]              hold_data_q, hold_data_d;
    logic [TX_DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [TX_DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    finished_q, finished_d;
    logic                    overflow_q, overflow_d;

    // RAM contents survive reset, so the array has no reset term
    logic [7:0] ram_mem [0:RAM_SIZE-1];
    logic [7:0] tx_mem  [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Bus strobes
    // ------------------------------------------------------------------
    logic       ram_we;
    logic       rx_read;
    logic       snap_take;
    logic       finish_wr;
    logic       push_req;
    logic [7:0] push_byte;
    logic       fifo_full;
    logic       pop;
    logic       push_ok;
    logic       rx_capture;

    assign ram_we     = cpu_wr && !is_io;
    assign rx_read    = !cpu_wr && is_io && (io_off == OFF_UART);
    assign snap_take  = !cpu_wr && is_io && (io_off == OFF_CNT_0);
    assign finish_wr  = cpu_wr && is_io && (io_off == OFF_CNT_0);

    // A zero byte written to the UART port is not a character and is dropped.
    // The finish write pushes 0x00 as an end-of-program marker for the host.
    assign push_req   = (cpu_wr && is_io && (io_off == OFF_UART) && (cpu_dout != 8'h00))
                        || finish_wr;
    assign push_byte  = finish_wr ? 8'h00 : cpu_dout;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign pop        = tx_valid && tx_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok    = push_req && (!fifo_full || pop);
    assign rx_capture = rx_valid && rx_ready;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_din          = cpu_din_q;
    assign tx_valid         = (count_q != '0);
    assign tx_data          = tx_mem[rd_ptr_q];

    // One slot of slack covers a write already in flight when the CPU samples this
    assign io_buffer_full   = (count_q >= CNT_W'(DEPTH - 1));
    assign rx_ready         = !hold_valid_q;
    assign program_finished = finished_q;
    assign tx_overflow      = overflow_q;

    // ------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------

    // RAM write port; the read is captured by the cpu_din register below
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= cpu_dout;
        end
    end

    // TX FIFO storage; queued bytes are discarded on reset through the pointers
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            tx_mem[wr_ptr_q] <= push_byte;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------

    // Next-state computation for read data, counter, RX holding and TX FIFO
    always_comb begin
        cpu_din_d    = cpu_din_q;
        cycle_d      = cycle_q + 32'd1;
        snap_d       = snap_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        finished_d   = finished_q || finish_wr;
        overflow_d   = overflow_q || (push_req && fifo_full && !pop);

        // Read data: a write cycle leaves the previous value on cpu_din
        if (!cpu_wr) begin
            if (!is_io) begin
                cpu_din_d = ram_mem[ram_addr];
            end else begin
                unique case (io_off)
                    OFF_UART:  cpu_din_d = hold_valid_q ? hold_data_q : 8'h00;
                    OFF_CNT_0: cpu_din_d = cycle_q[7:0];
                    OFF_CNT_1: cpu_din_d = snap_q[15:8];
                    OFF_CNT_2: cpu_din_d = snap_q[23:16];
                    OFF_CNT_3: cpu_din_d = snap_q[31:24];
                    default:   cpu_din_d = 8'h00;
                endcase
            end
        end

        // Byte 0 of the counter latches the whole dword so the upper bytes match it
        if (snap_take) begin
            snap_d = cycle_q;
        end

        // Capture only happens when empty, so it never collides with a clearing
        // read of a valid byte; capture wins the same-cycle empty-read case.
        if (rx_read) begin
            hold_valid_d = 1'b0;
        end
        if (rx_capture) begin
            hold_valid_d = 1'b1;
            hold_data_d  = rx_data;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + TX_DEPTH_BIT'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + TX_DEPTH_BIT'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control and data registers with asynchronous active-low clear
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cpu_din_q    <= 8'h00;
            cycle_q      <= 32'd0;
            snap_q       <= 32'd0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            finished_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cpu_din_q    <= cpu_din_d;
            cycle_q      <= cycle_d;
            snap_q       <= snap_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            finished_q   <= finished_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule
